// File: rtl/seq_det_pkg.sv
// Shared definitions for the time-shared serial pattern detector.
//   NCH_DEF / PAT_W_DEF / RST_PAT_DEF : default channel count, pattern width, reset pattern
//   ch_state_t                       : per-channel history + fill, sized for the largest PAT_W
//   fill_inc()                       : saturating fill-count increment
package seq_det_pkg;

    localparam int NCH_DEF   = 4;
    localparam int PAT_W_DEF = 4;
    localparam int PAT_MAX   = 8;
    localparam int FILL_W    = 4;

    localparam logic [PAT_W_DEF-1:0] RST_PAT_DEF = 4'b1010;

    // History is kept at PAT_MAX width; bits above PAT_W are always held at zero.
    typedef struct packed {
        logic [PAT_MAX-1:0] hist;
        logic [FILL_W-1:0]  fill;
    } ch_state_t;

    function automatic logic [FILL_W-1:0] fill_inc(input logic [FILL_W-1:0] f, input int lim);
        return (int'(f) >= lim) ? FILL_W'(lim) : f + 1'b1;
    endfunction

endpackage

// File: rtl/seq_detect_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr_i (wrapping).
//   req_i : request vector
//   ptr_i : search start position
//   gnt_o : one-hot grant (zero when no request)
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [N-1:0]         gnt_o
);

    localparam int CW = $clog2(N);

    logic          found;
    logic [CW-1:0] idx;

    // N is a power of two, so the CW-bit add wraps modulo N for free.
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = ptr_i;
        for (int k = 0; k < N; k++) begin
            idx = ptr_i + CW'(k);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_detect_sched.sv
// Time-shared serial pattern detector for NCH bit-serial channels.
//   clk, rst               : clock, async active-low reset
//   cfg_we/pattern/overlap : reload pattern and overlap mode, clears all channel state
//   en                     : grant enable
//   ch_valid/ch_bit        : per-channel serial bit request and data
//   ch_ready               : one-hot grant (bit consumed on valid & ready)
//   det_valid/det_ch       : registered one-cycle match pulse and channel
//   rd_sel/rd_cnt          : combinational read of a channel's saturating match counter
module seq_detect_sched
    import seq_det_pkg::*;
#(
    parameter int               NCH     = NCH_DEF,
    parameter int               PAT_W   = PAT_W_DEF,
    parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(RST_PAT_DEF)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_we,
    input  logic [PAT_W-1:0]       cfg_pattern,
    input  logic                   cfg_overlap,
    input  logic                   en,
    input  logic [NCH-1:0]         ch_valid,
    input  logic [NCH-1:0]         ch_bit,
    output logic [NCH-1:0]         ch_ready,
    output logic                   det_valid,
    output logic [$clog2(NCH)-1:0] det_ch,
    input  logic [$clog2(NCH)-1:0] rd_sel,
    output logic [7:0]             rd_cnt
);

    localparam int                 CW    = $clog2(NCH);
    localparam logic [PAT_MAX-1:0] HMASK = PAT_MAX'((1 << PAT_W) - 1);

    logic [CW-1:0]    ptr_q;
    logic [PAT_W-1:0] pat_q;
    logic             ovl_q;
    ch_state_t        bank_q [NCH];
    logic [7:0]       cnt_q  [NCH];
    logic             det_valid_q;
    logic [CW-1:0]    det_ch_q;

    logic [NCH-1:0]     req, gnt;
    logic               any_gnt;
    logic [CW-1:0]      g_idx;
    ch_state_t          cur;
    logic [PAT_MAX-1:0] hist_d;
    logic [FILL_W-1:0]  fill_d;
    logic               match;

    // Reset and config cycles never grant, so no bit can be lost to a clear.
    assign req = ch_valid & {NCH{en & ~cfg_we & rst}};

    rr_arbiter #(.N(NCH)) u_arb (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (gnt)
    );

    assign ch_ready  = gnt;
    assign any_gnt   = |gnt;
    assign det_valid = det_valid_q;
    assign det_ch    = det_ch_q;
    assign rd_cnt    = cnt_q[rd_sel];

    always_comb begin
        g_idx = '0;
        for (int i = 0; i < NCH; i++)
            if (gnt[i]) g_idx = CW'(i);
    end

    // Shared matcher: operates only on the granted channel's state.
    always_comb begin
        cur    = bank_q[g_idx];
        hist_d = ((cur.hist << 1) | PAT_MAX'(ch_bit[g_idx])) & HMASK;
        fill_d = fill_inc(cur.fill, PAT_W);
        match  = any_gnt && (hist_d == PAT_MAX'(pat_q)) && (fill_d == FILL_W'(PAT_W));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q       <= '0;
            pat_q       <= RST_PAT;
            ovl_q       <= 1'b1;
            det_valid_q <= 1'b0;
            det_ch_q    <= '0;
            for (int i = 0; i < NCH; i++) begin
                bank_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else if (cfg_we) begin
            pat_q       <= cfg_pattern;
            ovl_q       <= cfg_overlap;
            det_valid_q <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                bank_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else begin
            det_valid_q <= match;
            if (any_gnt) begin
                ptr_q              <= g_idx + 1'b1;
                bank_q[g_idx].hist <= hist_d;
                // Non-overlapping mode: history kept, but fill must rebuild before the next match.
                bank_q[g_idx].fill <= (match && !ovl_q) ? '0 : fill_d;
                if (match) begin
                    det_ch_q <= g_idx;
                    if (cnt_q[g_idx] != 8'hFF) cnt_q[g_idx] <= cnt_q[g_idx] + 8'd1;
                end
            end
        end
    end

endmodule
